// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_FLUSH = 3'd3,
    ST_INT   = 3'd4
  } hz_state_t;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_INT    = 2'd2;
  localparam logic [1:0] PC_RET    = 2'd3;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares every decoded source operand against a single destination register.
module hazard_match
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW             = 5,
  parameter int NUM_SRC            = 2,
  parameter int ZERO_REG_HARDWIRED = 0
) (
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         dst,
  input  logic                      wr_en,
  output logic                      match
);

  // Any valid operand reading the written register is a hit; r0 is exempt when hardwired.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && wr_en && (src_addr[i*REG_AW +: REG_AW] == dst) &&
          !((ZERO_REG_HARDWIRED != 0) && (src_addr[i*REG_AW +: REG_AW] == '0))) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, flush/interrupt/reset sequencing, memory stall hold.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW             = 5,
  parameter int NUM_SRC            = 2,
  parameter int FWD_EN             = 0,
  parameter int ZERO_REG_HARDWIRED = 0,
  parameter int EX_STALL_CYCLES    = 1,
  parameter int FLUSH_CYCLES       = 2,
  parameter int INT_CYCLES         = 2,
  parameter int RESET_CYCLES       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         ex_dst,
  input  logic                      ex_wr_en,
  input  logic                      ex_is_load,
  input  logic [REG_AW-1:0]         wb_dst,
  input  logic                      wb_wr_en,
  input  logic                      branch_mispredict,
  input  logic                      ret_detect,
  input  logic                      interrupt,
  input  logic                      mem_stall,
  output logic                      fetch_stall,
  output logic                      dec_stall,
  output logic                      dec_nop,
  output logic                      flush,
  output logic [1:0]                pc_sel,
  output logic                      pc_reset,
  output logic                      int_ack
);

  localparam int MAX_CYC = max_of4(EX_STALL_CYCLES, FLUSH_CYCLES, INT_CYCLES, RESET_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RESET_LD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LD = CNT_W'(EX_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] INT_LD   = CNT_W'(INT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_pend_q, int_pend_d;
  logic             irq_q, irq_d;
  logic             ex_hit, wb_hit, raw_ex, raw_wb, int_rise;

  hazard_match #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)
  ) u_match_ex (
    .src_addr(src_addr), .src_valid(src_valid), .dst(ex_dst), .wr_en(ex_wr_en), .match(ex_hit)
  );

  hazard_match #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)
  ) u_match_wb (
    .src_addr(src_addr), .src_valid(src_valid), .dst(wb_dst), .wr_en(wb_wr_en), .match(wb_hit)
  );

  // With forwarding only a load in EX can't be bypassed, and WB is always bypassed.
  always_comb begin
    raw_ex   = (FWD_EN != 0) ? (ex_hit && ex_is_load) : ex_hit;
    raw_wb   = (FWD_EN != 0) ? 1'b0 : wb_hit;
    int_rise = interrupt && !irq_q;
    irq_d    = interrupt;
  end

  // Next state and Mealy outputs. The RUN cycle that detects an event is the first
  // bubble cycle, so a counted state loaded with N-1 lasts N-1 cycles and leaves at cnt==1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    int_pend_d  = int_pend_q;
    fetch_stall = 1'b0;
    dec_stall   = 1'b0;
    dec_nop     = 1'b0;
    flush       = 1'b0;
    pc_sel      = PC_SEQ;
    pc_reset    = 1'b0;
    int_ack     = 1'b0;
    if (reset) begin
      pc_reset    = 1'b1;
      flush       = 1'b1;
      fetch_stall = 1'b1;
    end else begin
      case (state_q)
        ST_RESET: begin
          flush       = 1'b1;
          fetch_stall = 1'b1;
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        ST_RUN: begin
          if (mem_stall) begin
            fetch_stall = 1'b1;
            dec_stall   = 1'b1;
            if (int_rise) int_pend_d = 1'b1;
          end else if (interrupt || int_pend_q) begin
            pc_sel     = PC_INT;
            flush      = 1'b1;
            dec_nop    = 1'b1;
            int_ack    = 1'b1;
            int_pend_d = 1'b0;
            if (INT_CYCLES > 1) begin
              state_d = ST_INT;
              cnt_d   = INT_LD;
            end
          end else if (branch_mispredict || ret_detect) begin
            pc_sel  = branch_mispredict ? PC_BRANCH : PC_RET;
            flush   = 1'b1;
            dec_nop = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              cnt_d   = FLUSH_LD;
            end
          end else if (raw_ex) begin
            fetch_stall = 1'b1;
            dec_stall   = 1'b1;
            dec_nop     = 1'b1;
            if (EX_STALL_CYCLES > 1) begin
              state_d = ST_STALL;
              cnt_d   = STALL_LD;
            end
          end else if (raw_wb) begin
            fetch_stall = 1'b1;
            dec_stall   = 1'b1;
            dec_nop     = 1'b1;
          end
        end
        ST_STALL, ST_FLUSH, ST_INT: begin
          dec_nop = 1'b1;
          if (state_q == ST_STALL) begin
            fetch_stall = 1'b1;
            dec_stall   = 1'b1;
          end else begin
            flush = 1'b1;
          end
          if (interrupt && (state_q != ST_INT)) int_pend_d = 1'b1;
          if (mem_stall) begin
            fetch_stall = 1'b1;
            dec_stall   = 1'b1;
          end else if (cnt_q <= CNT_ONE) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: state_d = ST_RESET;
      endcase
    end
  end

  // Control registers; reset restarts the fill sequence and drops any deferred interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      cnt_q      <= RESET_LD;
      int_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
      irq_q      <= irq_d;
    end
  end

endmodule
